decoder_2to4_reg: RTL and testbench
===================================

// Module: decoder_2to4_reg
// PURPOSE
//  Registered binary-to-one-hot decoder: IN_W-bit select A drives exactly one of
//  2**IN_W output lines D. Defaults give a 2-to-4 decoder (A=00->D=0001 ... A=11->D=1000).
//  Used as an address/line-select front end, e.g. driving a 4x1 mux select or
//  enables from a 2-bit code. Outputs are registered to give glitch-free selects.
// PARAMETERS
//  IN_W        2  select width; output width OUT_W = 2**IN_W (localparam, not overridable)
//  REG_OUT     1  1: D/valid registered (1-cycle latency); 0: D/valid combinational from inputs
//  ACT_LOW     0  0: selected line = 1, others 0; 1: selected line = 0, others 1
// PORTS
//  clk     in   1        rising-edge clock
//  rst_n   in   1        asynchronous active-low reset
//  en      in   1        decode enable; when 0 all outputs inactive
//  A       in   IN_W     binary select code, A[IN_W-1] is MSB
//  D       out  OUT_W    one-hot decoded lines, D[i] selected when A==i
//  valid   out  1        D holds a decoded (active) pattern
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Decode: next_D[i] = en && (A == i), for i = 0..OUT_W-1.
//    Exactly one bit active when en=1; zero bits active when en=0. Never >1 active.
//  - Polarity: if ACT_LOW=1, D = ~next_D (inactive level is all ones).
//  - REG_OUT=1: D and valid update on rising clk only; latency 1 cycle from A/en
//    to D. Every cycle D reflects the A/en sampled at the previous edge; no hold,
//    no pipelining beyond 1 stage.
//  - REG_OUT=0: D = polarity(next_D), valid = en, purely combinational; clk unused.
//  - valid = en, delayed by the same latency as D.
//  - Reset (rst_n=0, async, any time incl. mid-sequence): D = inactive pattern
//    immediately (all 0; all 1 if ACT_LOW), valid = 0. Held while rst_n=0.
//    First update after rst_n deasserts occurs at the next rising clk edge.
//  - A changing every cycle: each code decoded independently, no skipped codes.
//  - A containing X/Z: D driven to X in simulation (no masking); not a
//    synthesized case.
//  - Width rules: A compared unsigned; all 2**IN_W codes are legal; no out-of-range
//    codes exist.
//  - No internal state other than the output registers; no handshake back-pressure.
// TESTING
//  1. Reset: rst_n=0 with en=1, A=10 -> D=0000, valid=0 asynchronously, before
//     any clk edge; release -> next edge D=0100, valid=1.
//  2. Sweep: en=1, A=00,01,10,11 on consecutive cycles -> one cycle later
//     D=0001,0010,0100,1000, valid=1 each cycle.
//  3. Enable: en=0, A=11 -> D=0000, valid=0 next cycle; en back to 1 ->
//     next cycle D=1000.
//  4. Mid-op reset: during sweep, assert rst_n between edges -> D=0000
//     at once; sweep resumes correctly after release.
//  5. Params: ACT_LOW=1, A=01 -> D=1101; IN_W=3, A=101 -> D=0010_0000;
//     REG_OUT=0, A=11 -> D=1000 same cycle.
//  6. Invariant check: random A/en for 1000 cycles -> $countones(active D)
//     == valid, and D index == A sampled one cycle earlier.

Source files
------------

// File: rtl/decoder_2to4_reg_if.sv
// Select-code / decoded-lines bundle for decoder_2to4_reg.
// The master drives the code and enable; the slave returns the decoded lines and valid.
interface decoder_2to4_reg_if #(
   parameter int IN_W = 2
);
   localparam int OUT_W = 2 ** IN_W;

   logic             en;
   logic [IN_W-1:0]  A;
   logic [OUT_W-1:0] D;
   logic             valid;

   modport master (
      output en,
      output A,
      input  D,
      input  valid
   );

   modport slave (
      input  en,
      input  A,
      output D,
      output valid
   );
endinterface

// File: rtl/decoder_2to4_reg.sv
// Binary-to-one-hot decoder with an optional output register stage.
// With the registered option, D and valid follow A/en one cycle later and
// are glitch-free. ACT_LOW inverts the line polarity so that the idle level
// is all ones. The A/en code seen at the previous clk edge is the only state
// that is kept.
module decoder_2to4_reg #(
   parameter int IN_W    = 2,
   parameter bit REG_OUT = 1'b1,
   parameter bit ACT_LOW = 1'b0
) (
   input logic               clk,
   input logic               rst_n,
   decoder_2to4_reg_if.slave bus
);
   localparam int OUT_W = 2 ** IN_W;
   localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACT_LOW}};

   logic [OUT_W-1:0] next_d;
   logic [OUT_W-1:0] d_comb;
   logic [OUT_W-1:0] d_q;
   logic             valid_q;

   // One-hot decode of A, gated by en (an X/Z on A propagates as X).
   always_comb begin
      // NOTE: a default assignment before the loop keeps every bit driven on all paths, so no latch is inferred.
      next_d = '0;
      for (int i = 0; i < OUT_W; i++) begin
         next_d[i] = bus.en & (bus.A == IN_W'(i));
      end
   end

   assign d_comb = ACT_LOW ? ~next_d : next_d;

   // Output register: the reset drives the idle level at once. After reset is released, the register loads the decode on each rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: async reset sits in the sensitivity list, and state uses non-blocking assignments only.
      if (!rst_n) begin
         d_q     <= INACTIVE;
         valid_q <= 1'b0;
      end else begin
         d_q     <= d_comb;
         valid_q <= bus.en;
      end
   end

   assign bus.D     = REG_OUT ? d_q     : d_comb;
   assign bus.valid = REG_OUT ? valid_q : bus.en;
endmodule

// File: tb/tb_decoder_2to4_reg.sv
// Directed bench for decoder_2to4_reg. It covers the default, active-low,
// 3-bit and combinational variants, and finishes with a random invariant run.
`timescale 1ns/1ps
module tb_decoder_2to4_reg;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   decoder_2to4_reg_if #(.IN_W(2)) if_a ();
   decoder_2to4_reg_if #(.IN_W(2)) if_l ();
   decoder_2to4_reg_if #(.IN_W(3)) if_w ();
   decoder_2to4_reg_if #(.IN_W(2)) if_c ();

   decoder_2to4_reg #(.IN_W(2), .REG_OUT(1'b1), .ACT_LOW(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   decoder_2to4_reg #(.IN_W(2), .REG_OUT(1'b1), .ACT_LOW(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l.slave));
   decoder_2to4_reg #(.IN_W(3), .REG_OUT(1'b1), .ACT_LOW(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));
   decoder_2to4_reg #(.IN_W(2), .REG_OUT(1'b0), .ACT_LOW(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] a_prev;
      logic       en_prev;
      logic [3:0] d_exp;
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      if_a.en = 1'b1; if_a.A = 2'b10;
      if_l.en = 1'b1; if_l.A = 2'b01;
      if_w.en = 1'b1; if_w.A = 3'b101;
      if_c.en = 1'b1; if_c.A = 2'b11;

      // 1. async reset before any clock edge, then release
      #2 rst_n = 1'b0;
      #1;
      check("rst_d_async", 32'(if_a.D), 32'h0);
      check("rst_valid_async", 32'(if_a.valid), 32'h0);
      check("rst_actlow_idle", 32'(if_l.D), 32'hf);
      repeat (2) @(posedge clk);
      #1;
      check("rst_d_held", 32'(if_a.D), 32'h0);
      check("rst_valid_held", 32'(if_a.valid), 32'h0);
      #3 rst_n = 1'b1;
      step();
      check("rst_release_d", 32'(if_a.D), 32'h4);
      check("rst_release_valid", 32'(if_a.valid), 32'h1);

      // 2. sweep all codes on consecutive cycles
      for (int i = 0; i < 4; i++) begin
         if_a.A = 2'(i);
         step();
         check($sformatf("sweep_d_%0d", i), 32'(if_a.D), 32'(1 << i));
         check($sformatf("sweep_valid_%0d", i), 32'(if_a.valid), 32'h1);
      end

      // 3. enable low then high
      if_a.en = 1'b0; if_a.A = 2'b11;
      step();
      check("en0_d", 32'(if_a.D), 32'h0);
      check("en0_valid", 32'(if_a.valid), 32'h0);
      if_a.en = 1'b1;
      step();
      check("en1_d", 32'(if_a.D), 32'h8);
      check("en1_valid", 32'(if_a.valid), 32'h1);

      // 4. reset asserted between edges during a sweep
      if_a.A = 2'b01;
      step();
      check("mid_pre_d", 32'(if_a.D), 32'h2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_d", 32'(if_a.D), 32'h0);
      check("mid_rst_valid", 32'(if_a.valid), 32'h0);
      if_a.A = 2'b10;
      #1 rst_n = 1'b1;
      step();
      check("mid_resume_d", 32'(if_a.D), 32'h4);
      if_a.A = 2'b11;
      step();
      check("mid_resume_d2", 32'(if_a.D), 32'h8);

      // 5. parameter variants
      check("actlow_d", 32'(if_l.D), 32'hd);
      check("actlow_valid", 32'(if_l.valid), 32'h1);
      check("inw3_d", 32'(if_w.D), 32'h20);
      if_l.en = 1'b0;
      step();
      check("actlow_en0_d", 32'(if_l.D), 32'hf);
      #2;
      check("comb_d_11", 32'(if_c.D), 32'h8);
      check("comb_valid", 32'(if_c.valid), 32'h1);
      if_c.A = 2'b00;
      #1;
      check("comb_d_00", 32'(if_c.D), 32'h1);
      if_c.en = 1'b0;
      #1;
      check("comb_en0_d", 32'(if_c.D), 32'h0);
      check("comb_en0_valid", 32'(if_c.valid), 32'h0);

      // 6. random invariant run
      step();
      for (int n = 0; n < 1000; n++) begin
         a_prev  = 2'($urandom_range(0, 3));
         en_prev = 1'($urandom_range(0, 1));
         if_a.A  = a_prev;
         if_a.en = en_prev;
         d_exp   = en_prev ? (4'b0001 << a_prev) : 4'b0000;
         step();
         check("rand_d", 32'(if_a.D), 32'(d_exp));
         check("rand_valid", 32'(if_a.valid), 32'(en_prev));
         check("rand_onehot", 32'($countones(if_a.D)), 32'(if_a.valid));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
